// File: rtl/tdm_pkg.sv
// Shared constants and state type for the 16:1 TDM receive demultiplexer.
// Build with TDM_DEMUX_PARITY_EN defined to add a trailing even-parity slot per frame.
package tdm_pkg;
    localparam int N_CH         = 16;
    localparam int PARITY_SLOTS = 17;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int N_SLOT = PARITY_SLOTS;
    localparam int SEL_W  = 5;
`else
    localparam int N_SLOT = N_CH;
    localparam int SEL_W  = 4;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: increments when enabled, wraps after the last slot,
// and can be loaded to 1 when a slot-0 sample starts a new frame.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load1,
    output logic [SEL_W-1:0] sel,
    output logic             tc
);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_SLOT - 1);

    assign tc = (sel == LAST_SLOT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
        end else if (load1) begin
            sel <= SEL_W'(1);
        end else if (inc) begin
            sel <= tc ? '0 : sel + 1'b1;
        end
    end
endmodule

// File: rtl/tdm_demux16.sv
// Receive side of a 16:1 TDM serial link: rebuilds each frame into a parallel word.
// Optional TDM_DEMUX_PARITY_EN adds a 17th even-parity slot and a parity_err pulse.
module tdm_demux16
    import tdm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             frame_sync,
    input  logic             data_in,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  data_out,
    output logic             data_valid,
    output logic             frame_err,
`ifdef TDM_DEMUX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);
    state_t          state, next_state;
    logic [N_CH-1:0] shadow;
    logic            tc;
    logic            load1, inc, wr, complete, misalign, data_slot;
    logic [3:0]      wr_idx;

    tdm_slot_ctr u_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc),
        .load1 (load1),
        .sel   (sel),
        .tc    (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A sync bit always restarts at slot 0; it is an error only if a frame was partly received.
    always_comb begin
        next_state = state;
        load1      = 1'b0;
        inc        = 1'b0;
        wr         = 1'b0;
        complete   = 1'b0;
        misalign   = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (frame_sync) begin
                        load1      = 1'b1;
                        wr         = 1'b1;
                        next_state = RUN;
                    end
                end
                RUN: begin
                    wr = 1'b1;
                    if (frame_sync) begin
                        load1    = 1'b1;
                        misalign = (sel != '0);
                    end else begin
                        inc      = 1'b1;
                        complete = tc;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign wr_idx = load1 ? 4'd0 : sel[3:0];
    assign busy   = (state == RUN);

`ifdef TDM_DEMUX_PARITY_EN
    // The parity slot is never stored; it is consumed directly at completion.
    assign data_slot = load1 || !tc;
`else
    assign data_slot = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= misalign;
`ifdef TDM_DEMUX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (wr && data_slot) begin
                shadow[wr_idx] <= data_in;
            end
            if (complete) begin
                data_valid <= 1'b1;
`ifdef TDM_DEMUX_PARITY_EN
                data_out   <= shadow;
                parity_err <= (^shadow) ^ data_in;
`else
                data_out   <= {data_in, shadow[N_CH-2:0]};
`endif
            end
        end
    end
endmodule
